seg7_scan_mmio: RTL and testbench

Parametrised, memory-mapped 7-segment scan controller: successor to the fixed 16-nibble display path on the board top. The CPU's memory-mapped I/O bus writes data and control registers with byte enables. The block time-multiplexes DIGITS hex digits onto one shared segment bus and adds per-digit blink, decimal-point masks and leading-zero blanking. It sits between the MIO bus decode (seg7 chip select) and the board segment/anode pins, and runs on the system clock, not the CPU clock.

---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_scan_mmio_if.sv | 11 +
 rtl/seg7_hex_decode.sv | 33 +++
 rtl/seg7_scan_mmio.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_mmio.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the memory-mapped 7-segment scan controller:
// register map, CTRL bit positions, active-high hex segment patterns.
package seg7_pkg;

    localparam logic [1:0] SEG7_DATA  = 2'd0;
    localparam logic [1:0] SEG7_CTRL  = 2'd1;
    localparam logic [1:0] SEG7_BLINK = 2'd2;
    localparam logic [1:0] SEG7_DP    = 2'd3;

    localparam int CTRL_W        = 3;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_LZB      = 2;

    // Segment order g..a, bit 0 = a.
    localparam logic [6:0] SEG7_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG7_HEX_1 = 7'h06;
    localparam logic [6:0] SEG7_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG7_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG7_HEX_4 = 7'h66;
    localparam logic [6:0] SEG7_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG7_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG7_HEX_7 = 7'h07;
    localparam logic [6:0] SEG7_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG7_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG7_HEX_A = 7'h77;
    localparam logic [6:0] SEG7_HEX_B = 7'h7C;
    localparam logic [6:0] SEG7_HEX_C = 7'h39;
    localparam logic [6:0] SEG7_HEX_D = 7'h5E;
    localparam logic [6:0] SEG7_HEX_E = 7'h79;
    localparam logic [6:0] SEG7_HEX_F = 7'h71;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wd[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_mmio_if.sv
// MMIO register bus between the seg7 chip-select decode and the scan controller.
interface seg7_scan_mmio_if;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  amp;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, amp, wdata, input rdata);
    modport slave  (input we, addr, amp, wdata, output rdata);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Hex lookup.
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0:    seg = SEG7_HEX_0;
            4'h1:    seg = SEG7_HEX_1;
            4'h2:    seg = SEG7_HEX_2;
            4'h3:    seg = SEG7_HEX_3;
            4'h4:    seg = SEG7_HEX_4;
            4'h5:    seg = SEG7_HEX_5;
            4'h6:    seg = SEG7_HEX_6;
            4'h7:    seg = SEG7_HEX_7;
            4'h8:    seg = SEG7_HEX_8;
            4'h9:    seg = SEG7_HEX_9;
            4'hA:    seg = SEG7_HEX_A;
            4'hB:    seg = SEG7_HEX_B;
            4'hC:    seg = SEG7_HEX_C;
            4'hD:    seg = SEG7_HEX_D;
            4'hE:    seg = SEG7_HEX_E;
            4'hF:    seg = SEG7_HEX_F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mmio.sv
// Memory-mapped 7-segment scan controller: register file, digit scan,
// blink phase, leading-zero blanking and registered segment/anode drive.
module seg7_scan_mmio
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_CNT   = 100000,
    parameter int BLINK_CNT  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_mmio_if.slave   bus,
    output logic [7:0]        seg_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W  = $clog2(SCAN_CNT);
    localparam int RND_W  = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_CNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [RND_W-1:0]  RND_LAST = RND_W'(BLINK_CNT - 1);
    localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [DATA_W-1:0] data_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DIGITS-1:0] blink_r;
    logic [DIGITS-1:0] dp_r;

    logic [PRE_W-1:0]  pre_r;
    logic [IDX_W-1:0]  idx_r;
    logic [RND_W-1:0]  rnd_r;
    logic              ph_r;

    logic [31:0]       rdata_s;
    logic [31:0]       wr_merge_s;
    logic [3:0]        nibble_s;
    logic [6:0]        hex_s;
    logic [DATA_W-1:0] upper_s;
    logic              blank_s;
    logic [7:0]        seg_nxt_s;
    logic [DIGITS-1:0] an_nxt_s;

    // Zero-extended readback of the addressed register.
    always_comb begin
        rdata_s = 32'h0;
        case (bus.addr)
            SEG7_DATA:  rdata_s = 32'(data_r);
            SEG7_CTRL:  rdata_s = 32'(ctrl_r);
            SEG7_BLINK: rdata_s = 32'(blink_r);
            SEG7_DP:    rdata_s = 32'(dp_r);
            default:    rdata_s = 32'h0;
        endcase
    end

    assign bus.rdata  = rdata_s;
    // The readback value doubles as the old contents for byte-lane merging.
    assign wr_merge_s = byte_merge(rdata_s, bus.wdata, bus.amp);

    // Register file writes with byte enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            ctrl_r  <= CTRL_W'(1);
            blink_r <= '0;
            dp_r    <= '0;
        end else if (bus.we) begin
            case (bus.addr)
                SEG7_DATA:  data_r  <= wr_merge_s[DATA_W-1:0];
                SEG7_CTRL:  ctrl_r  <= wr_merge_s[CTRL_W-1:0];
                SEG7_BLINK: blink_r <= wr_merge_s[DIGITS-1:0];
                SEG7_DP:    dp_r    <= wr_merge_s[DIGITS-1:0];
                default:    data_r  <= data_r;
            endcase
        end
    end

    // Prescaler, digit index, scan-round counter and blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
            idx_r <= '0;
            rnd_r <= '0;
            ph_r  <= 1'b0;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= '0;
            if (idx_r == IDX_LAST) begin
                idx_r <= '0;
                if (rnd_r == RND_LAST) begin
                    rnd_r <= '0;
                    ph_r  <= ~ph_r;
                end else begin
                    rnd_r <= rnd_r + RND_W'(1);
                end
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    assign nibble_s = data_r[{idx_r, 2'b00} +: 4];
    assign upper_s  = data_r >> {idx_r, 2'b00};

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_s),
        .seg    (hex_s)
    );

    // Blanking decision and polarity for the selected digit.
    always_comb begin
        blank_s = (!ctrl_r[CTRL_EN])
               || (ctrl_r[CTRL_BLINK_EN] && blink_r[idx_r] && ph_r)
               || (ctrl_r[CTRL_LZB] && (idx_r != '0) && (upper_s == '0));
        if (blank_s) begin
            seg_nxt_s = 8'h00;
        end else begin
            seg_nxt_s = {dp_r[idx_r], hex_s};
        end
        if (ctrl_r[CTRL_EN]) begin
            an_nxt_s = DIGITS'(1) << idx_r;
        end else begin
            an_nxt_s = '0;
        end
        if (ACTIVE_LOW != 0) begin
            seg_nxt_s = ~seg_nxt_s;
            an_nxt_s  = ~an_nxt_s;
        end else begin
            seg_nxt_s = seg_nxt_s;
            an_nxt_s  = an_nxt_s;
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_o <= SEG_OFF;
            an_o  <= AN_OFF;
        end else begin
            seg_o <= seg_nxt_s;
            an_o  <= an_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mmio.sv
// Directed self-checking bench for seg7_scan_mmio (8 digits, 4-cycle slots,
// 2-round blink, active-low pins).
module tb_seg7_scan_mmio;
    import seg7_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_o;
    logic [7:0] an_o;
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         edge_n       = 0;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] scan_seg [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    seg7_scan_mmio_if bus ();

    seg7_scan_mmio #(
        .DIGITS     (8),
        .SCAN_CNT   (4),
        .BLINK_CNT  (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .seg_o (seg_o),
        .an_o  (an_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release: after edge n, edge_n == n.
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [7:0] e_an, input logic [7:0] e_seg);
        check({tag, "_an"}, {24'h0, an_o}, {24'h0, e_an});
        check({tag, "_seg"}, {24'h0, seg_o}, {24'h0, e_seg});
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.amp   = be;
        bus.wdata = d;
        @(negedge clk);
        bus.we  = 1'b0;
        bus.amp = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.amp   = 4'h0;
        bus.wdata = 32'h0;

        // Reset: outputs go inactive at once and hold.
        #2 rst = 1'b1;
        #1 check_pins("rst_async", 8'hFF, 8'hFF);
        @(negedge clk);
        check_pins("rst_hold", 8'hFF, 8'hFF);
        check_rd("rst_ctrl", SEG7_CTRL, 32'h1);
        check_rd("rst_data", SEG7_DATA, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_pins("rel_first", 8'hFE, 8'hC0);

        // Scan across all eight digits and back to digit 0.
        bus_write(SEG7_DATA, 4'hF, 32'h7654_3210);
        for (int e = 2; e <= 34; e++) begin
            exp_an  = ~(8'h01 << (((e - 1) / 4) % 8));
            exp_seg = scan_seg[((e - 1) / 4) % 8];
            check_pins("scan", exp_an, exp_seg);
            @(negedge clk);
        end

        // Byte enables and out-of-range bits.
        bus_write(SEG7_DATA, 4'b0010, 32'hAABB_CCDD);
        check_rd("be_data", SEG7_DATA, 32'h7654_CC10);
        bus_write(SEG7_DATA, 4'b0000, 32'hFFFF_FFFF);
        check_rd("be_noop", SEG7_DATA, 32'h7654_CC10);
        bus_write(SEG7_CTRL, 4'hF, 32'hFFFF_FFFF);
        check_rd("be_ctrl", SEG7_CTRL, 32'h0000_0007);
        bus_write(SEG7_BLINK, 4'b0001, 32'h1234_5678);
        check_rd("be_blink", SEG7_BLINK, 32'h0000_0078);
        bus_write(SEG7_DP, 4'b1110, 32'hFFFF_FFFF);
        check_rd("be_dp", SEG7_DP, 32'h0);

        // Leading-zero blanking and decimal point.
        do_reset();
        bus_write(SEG7_DATA, 4'hF, 32'h0000_0A05);
        bus_write(SEG7_CTRL, 4'hF, 32'h0000_0005);
        bus_write(SEG7_DP, 4'hF, 32'h0000_0001);
        wait_to(4);
        check_pins("lzb_d0", 8'hFE, 8'h12);
        wait_to(5);
        check_pins("lzb_d1", 8'hFD, 8'hC0);
        wait_to(9);
        check_pins("lzb_d2", 8'hFB, 8'h88);
        wait_to(13);
        check_pins("lzb_d3", 8'hF7, 8'hFF);
        // A write to the selected digit shows one edge later.
        bus_write(SEG7_DATA, 4'hF, 32'h0000_3A05);
        check_pins("wr_lat0", 8'hF7, 8'hFF);
        wait_to(15);
        check_pins("wr_lat1", 8'hF7, 8'hB0);

        // Blink on digit 0 only.
        do_reset();
        bus_write(SEG7_CTRL, 4'hF, 32'h0000_0003);
        bus_write(SEG7_BLINK, 4'hF, 32'h0000_0001);
        wait_to(33);
        check_pins("blink_on0", 8'hFE, 8'hC0);
        wait_to(65);
        check_pins("blink_off0", 8'hFE, 8'hFF);
        wait_to(69);
        check_pins("blink_d1", 8'hFD, 8'hC0);
        wait_to(97);
        check_pins("blink_off1", 8'hFE, 8'hFF);
        wait_to(129);
        check_pins("blink_on1", 8'hFE, 8'hC0);
        wait_to(213);
        check_pins("pre_rst_d5", 8'hDF, 8'hC0);

        // Reset mid-scan with idx=5, ph=1.
        wait_to(214);
        rst = 1'b1;
        #1 check_pins("mid_rst", 8'hFF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check_pins("mid_rst_hold", 8'hFF, 8'hFF);
        rst = 1'b0;
        wait_to(1);
        check_pins("mid_rel", 8'hFE, 8'hC0);
        check_rd("mid_ctrl", SEG7_CTRL, 32'h1);
        check_rd("mid_blink", SEG7_BLINK, 32'h0);
        wait_to(4);
        check_pins("mid_slot_end", 8'hFE, 8'hC0);
        wait_to(5);
        check_pins("mid_next", 8'hFD, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
